alu_arbiter: RTL and testbench
==============================

# alu_arbiter

Two-port arbiter and sequencer that shares one combinational ALU between the core datapath (port 0) and the UART debug/command path (port 1). It accepts one operation at a time over a valid/ready request handshake and drives registered operands and the opcode into the ALU. It captures the result and zero flag and returns them on the winning port's valid/ready response channel. It sits between the core/UART front-ends and the single `ALU` instance.

## Interface
- `WIDTH`, default 32: operand and result width, which must equal the ALU width.
- `clk  in  1`: single clock; all state updates on the rising edge.
- `rst_n  in  1`: reset, synchronous, active-low.
- `req0_valid  in  1` / `req0_ready  out  1`: core request handshake.
- `req0_a`, `req0_b  in  WIDTH`; `req0_sel  in  3`: core operands and ALU opcode.
- `req1_valid  in  1` / `req1_ready  out  1`; `req1_a`, `req1_b  in  WIDTH`; `req1_sel  in  3`: UART request channel.
- `rsp0_valid  out  1` / `rsp0_ready  in  1`; `rsp0_result  out  WIDTH`; `rsp0_zero  out  1`: core response.
- `rsp1_valid  out  1` / `rsp1_ready  in  1`; `rsp1_result  out  WIDTH`; `rsp1_zero  out  1`: UART response.
- `alu_a`, `alu_b  out  WIDTH`; `alu_sel  out  3`: registered drive to the ALU.
- `alu_out  in  WIDTH`; `alu_zero  in  1`: ALU result and zero flag (combinational from `alu_*`).

## Operation
- FSM states:
  - IDLE, encoding 2'b00.
  - EXEC, encoding 2'b01.
  - RESP, encoding 2'b10.
  - Any other encoding goes to IDLE.
- IDLE:
  - Grant is computed from `req*_valid`.
  - `reqN_ready = (state==IDLE) && grant==N && reqN_valid`.
  - On handshake, latch a/b/sel into `alu_a/alu_b/alu_sel`, record owner N and `last_grant<=N`, then go to EXEC.
- EXEC: `alu_*` stable; at the clock edge, capture `alu_out` into the result register and `alu_zero` into the zero register; go to RESP.
- RESP:
  - `rspN_valid=1` for the owner only; the other port's `rsp_valid` stays 0.
  - Result and zero are held until `rspN_ready`, then go to IDLE.
  - No new request is accepted in EXEC or RESP; both `req*_ready=0`.
- Arbitration:
  - Round-robin. A single valid requester wins.
  - When both are valid, the port not equal to `last_grant` wins.
  - `last_grant` resets to 1, so port 0 wins the first tie.
- Requesters must hold valid and payload stable until ready. Responders may assert ready at any time. Ready may depend on valid; valid never depends on ready.
- Opcodes are passed through unmodified; the arbiter does not decode them. Unknown codes give whatever the ALU returns (ADD default).
- Reset values:
  - state=IDLE.
  - `alu_a/alu_b=0`, `alu_sel=3'b010` (ADD).
  - Result register 0, zero register 0.
  - `rsp*_valid=0`, `req*_ready=0`, `last_grant=1`.
- Reset mid-operation: any in-flight op is discarded with no response; all outputs take reset values after the edge where `rst_n=0`.
- `rspN_result/rspN_zero` show the captured registers on both ports. They are meaningful only while `rspN_valid`.

## Timing
- Request handshake at edge T, then EXEC at cycle T+1.
- `rspN_valid` is first high in cycle T+2. Minimum request-to-response latency is 2 cycles.
- If `rspN_ready` is high in cycle T+2, state is IDLE at T+3 and the next request can handshake at the T+3 edge. Back-to-back throughput is 1 op per 3 cycles.
- Response backpressure stretches RESP indefinitely, with no loss and no change to result or zero.
- Both valid at the same edge: only one handshake happens; the loser keeps `valid` and is served next.

## Configuration
- `ALU_ARB_FIXED_PRIO_EN`:
  - Defined: fixed priority. Port 0 always wins when both are valid; `last_grant` is still tracked but ignored.
  - Undefined (default): round-robin as described above.

## Structure
- Package `alu_pkg`:
  - Opcode localparams: AND 3'b000, OR 3'b001, ADD 3'b010, SUB 3'b110, SLL 3'b111, SRL 3'b011, SLT 3'b100, MUL 3'b101.
  - FSM state typedef/encodings.
  - Reset opcode constant.
- Sub-module `alu_arb_picker`: combinational 2-way grant from the two valids, `last_grant` and the config macro. Outputs grant index and grant-valid.
- The ALU itself stays outside this block and is connected at the level above.

## Test plan
- `req0` ADD a=5, b=3 after reset, `rsp0_ready=1` -> `rsp0_valid` at T+2, result 8, zero 0, `rsp1_valid` stays 0.
- Both valid in the first cycle after reset (`req0` SUB 7−7, `req1` OR 0x0F|0xF0) -> `req0` served first with result 0, zero 1; then `req1` with result 0xFF, zero 0. A third tie then grants `req1` first (round-robin), or `req0` first with `ALU_ARB_FIXED_PRIO_EN`.
- `req1` SLL a=1, b=4 with `rsp1_ready` low for 3 cycles -> `rsp1_valid` held with result 16 throughout; state returns to IDLE one cycle after ready.
- `req0` held valid while `req1` is in RESP -> `req0_ready` stays 0 until RESP exits; no payload is corrupted.
- `rst_n` low in EXEC -> next cycle `rsp*_valid=0`, `alu_sel=ADD`, `alu_a=alu_b=0`, and no response is ever issued for the aborted op.
- `req0` SLT a=−2, b=1 (signed) -> result 1, zero 0; MUL a=6, b=7 -> result 42.

Source files
------------

// File: rtl/alu_pkg.sv
// ============================================================================
// Module      : alu_pkg
// Description : Shared opcodes, reset opcode and FSM state encoding for the
//               ALU arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_pkg;

    localparam logic [2:0] c_OP_AND = 3'b000;
    localparam logic [2:0] c_OP_OR  = 3'b001;
    localparam logic [2:0] c_OP_ADD = 3'b010;
    localparam logic [2:0] c_OP_SUB = 3'b110;
    localparam logic [2:0] c_OP_SLL = 3'b111;
    localparam logic [2:0] c_OP_SRL = 3'b011;
    localparam logic [2:0] c_OP_SLT = 3'b100;
    localparam logic [2:0] c_OP_MUL = 3'b101;

    localparam logic [2:0] c_RST_OP = c_OP_ADD;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_EXEC = 2'b01,
        ST_RESP = 2'b10
    } arb_state_t;

endpackage : alu_pkg

`default_nettype wire

// File: rtl/alu_arb_picker.sv
// ============================================================================
// Module      : alu_arb_picker
// Description : Combinational two-way grant selection. Round-robin on ties by
//               default; fixed priority to port 0 when ALU_ARB_FIXED_PRIO_EN
//               is defined.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arb_picker (
    input  logic i_valid0,
    input  logic i_valid1,
    input  logic i_last_grant,
    output logic o_grant,
    output logic o_grant_valid
);

    logic w_tie_grant;

`ifdef ALU_ARB_FIXED_PRIO_EN
    logic w_unused_last_grant;
    assign w_unused_last_grant = i_last_grant;
    assign w_tie_grant         = 1'b0;
`else
    // On a tie, the port that did not win last time goes next.
    assign w_tie_grant = ~i_last_grant;
`endif

    always_comb begin
        o_grant_valid = i_valid0 | i_valid1;
        o_grant       = 1'b0;
        if (i_valid0 && i_valid1) begin
            o_grant = w_tie_grant;
        end else begin
            o_grant = i_valid1;
        end
    end

endmodule : alu_arb_picker

`default_nettype wire

// File: rtl/alu_arbiter.sv
// ============================================================================
// Module      : alu_arbiter
// Description : Shares one external combinational ALU between the core (port 0)
//               and UART (port 1) over valid/ready channels. Config macro:
//               ALU_ARB_FIXED_PRIO_EN (port 0 wins ties when defined).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_arbiter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,

    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [WIDTH-1:0] req0_a,
    input  logic [WIDTH-1:0] req0_b,
    input  logic [2:0]       req0_sel,

    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [WIDTH-1:0] req1_a,
    input  logic [WIDTH-1:0] req1_b,
    input  logic [2:0]       req1_sel,

    output logic             rsp0_valid,
    input  logic             rsp0_ready,
    output logic [WIDTH-1:0] rsp0_result,
    output logic             rsp0_zero,

    output logic             rsp1_valid,
    input  logic             rsp1_ready,
    output logic [WIDTH-1:0] rsp1_result,
    output logic             rsp1_zero,

    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic [2:0]       alu_sel,
    input  logic [WIDTH-1:0] alu_out,
    input  logic             alu_zero
);

    arb_state_t       r_state;
    arb_state_t       w_state_next;
    logic             r_owner;
    logic             r_last_grant;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [2:0]       r_alu_sel;
    logic [WIDTH-1:0] r_result;
    logic             r_zero;

    logic             w_grant;
    logic             w_grant_valid;
    logic             w_idle;
    logic             w_handshake;
    logic             w_rsp_accept;

    alu_arb_picker u_picker (
        .i_valid0      (req0_valid),
        .i_valid1      (req1_valid),
        .i_last_grant  (r_last_grant),
        .o_grant       (w_grant),
        .o_grant_valid (w_grant_valid)
    );

    assign w_idle       = (r_state == ST_IDLE);
    assign req0_ready   = w_idle && w_grant_valid && !w_grant && req0_valid;
    assign req1_ready   = w_idle && w_grant_valid &&  w_grant && req1_valid;
    assign w_handshake  = req0_ready | req1_ready;
    assign w_rsp_accept = r_owner ? rsp1_ready : rsp0_ready;

    always_comb begin
        w_state_next = ST_IDLE;
        case (r_state)
            ST_IDLE: w_state_next = w_handshake ? ST_EXEC : ST_IDLE;
            ST_EXEC: w_state_next = ST_RESP;
            ST_RESP: w_state_next = w_rsp_accept ? ST_IDLE : ST_RESP;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_owner      <= 1'b0;
            r_last_grant <= 1'b1;
            r_alu_a      <= '0;
            r_alu_b      <= '0;
            r_alu_sel    <= c_RST_OP;
            r_result     <= '0;
            r_zero       <= 1'b0;
        end else begin
            r_state <= w_state_next;
            if (w_handshake) begin
                // req1_ready alone identifies the winner of this handshake.
                r_owner      <= req1_ready;
                r_last_grant <= req1_ready;
                r_alu_a      <= req1_ready ? req1_a   : req0_a;
                r_alu_b      <= req1_ready ? req1_b   : req0_b;
                r_alu_sel    <= req1_ready ? req1_sel : req0_sel;
            end
            if (r_state == ST_EXEC) begin
                r_result <= alu_out;
                r_zero   <= alu_zero;
            end
        end
    end

    assign alu_a       = r_alu_a;
    assign alu_b       = r_alu_b;
    assign alu_sel     = r_alu_sel;

    assign rsp0_valid  = (r_state == ST_RESP) && !r_owner;
    assign rsp1_valid  = (r_state == ST_RESP) &&  r_owner;
    assign rsp0_result = r_result;
    assign rsp1_result = r_result;
    assign rsp0_zero   = r_zero;
    assign rsp1_zero   = r_zero;

endmodule : alu_arbiter

`default_nettype wire

// File: tb/tb_alu_arbiter.sv
// ============================================================================
// Module      : tb_alu_arbiter
// Description : Directed self-checking bench for alu_arbiter with a reference
//               ALU model attached. Honours ALU_ARB_FIXED_PRIO_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_alu_arbiter;

    localparam int WIDTH = 32;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_SLL = 3'b111;
    localparam logic [2:0] OP_SRL = 3'b011;
    localparam logic [2:0] OP_SLT = 3'b100;
    localparam logic [2:0] OP_MUL = 3'b101;

    logic             clk;
    logic             rst_n;
    logic             req0_valid, req0_ready, req1_valid, req1_ready;
    logic [WIDTH-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [2:0]       req0_sel, req1_sel;
    logic             rsp0_valid, rsp0_ready, rsp0_zero;
    logic             rsp1_valid, rsp1_ready, rsp1_zero;
    logic [WIDTH-1:0] rsp0_result, rsp1_result;
    logic [WIDTH-1:0] alu_a, alu_b, alu_out;
    logic [2:0]       alu_sel;
    logic             alu_zero;

    int n_checks = 0;
    int n_errors = 0;

    alu_arbiter #(.WIDTH(WIDTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0_valid  (req0_valid),
        .req0_ready  (req0_ready),
        .req0_a      (req0_a),
        .req0_b      (req0_b),
        .req0_sel    (req0_sel),
        .req1_valid  (req1_valid),
        .req1_ready  (req1_ready),
        .req1_a      (req1_a),
        .req1_b      (req1_b),
        .req1_sel    (req1_sel),
        .rsp0_valid  (rsp0_valid),
        .rsp0_ready  (rsp0_ready),
        .rsp0_result (rsp0_result),
        .rsp0_zero   (rsp0_zero),
        .rsp1_valid  (rsp1_valid),
        .rsp1_ready  (rsp1_ready),
        .rsp1_result (rsp1_result),
        .rsp1_zero   (rsp1_zero),
        .alu_a       (alu_a),
        .alu_b       (alu_b),
        .alu_sel     (alu_sel),
        .alu_out     (alu_out),
        .alu_zero    (alu_zero)
    );

    // Reference ALU sitting where the real one would be.
    always_comb begin
        alu_out = alu_a + alu_b;
        case (alu_sel)
            OP_AND: alu_out = alu_a & alu_b;
            OP_OR:  alu_out = alu_a | alu_b;
            OP_ADD: alu_out = alu_a + alu_b;
            OP_SUB: alu_out = alu_a - alu_b;
            OP_SLL: alu_out = alu_a << alu_b[4:0];
            OP_SRL: alu_out = alu_a >> alu_b[4:0];
            OP_SLT: alu_out = {31'b0, ($signed(alu_a) < $signed(alu_b))};
            OP_MUL: alu_out = alu_a * alu_b;
            default: alu_out = alu_a + alu_b;
        endcase
        alu_zero = (alu_out == '0);
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, expected finish before timeout");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic issue(input int port, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] sel);
        if (port == 0) begin
            req0_a = a; req0_b = b; req0_sel = sel; req0_valid = 1'b1;
        end else begin
            req1_a = a; req1_b = b; req1_sel = sel; req1_valid = 1'b1;
        end
    endtask

    // Handshake on `port`, then check latency, response and return to IDLE.
    task automatic serve(input int port, input logic [31:0] er, input logic ez,
                         input string tag);
        #1;
        chk({tag, "_ready"},       (port == 0) ? req0_ready : req1_ready, 32'd1);
        chk({tag, "_other_ready"}, (port == 0) ? req1_ready : req0_ready, 32'd0);
        tick();
        if (port == 0) req0_valid = 1'b0; else req1_valid = 1'b0;
        chk({tag, "_exec_valid"},  (port == 0) ? rsp0_valid : rsp1_valid, 32'd0);
        tick();
        chk({tag, "_rsp_valid"},   (port == 0) ? rsp0_valid : rsp1_valid, 32'd1);
        chk({tag, "_rsp_other"},   (port == 0) ? rsp1_valid : rsp0_valid, 32'd0);
        chk({tag, "_result"},      (port == 0) ? rsp0_result : rsp1_result, er);
        chk({tag, "_zero"},        (port == 0) ? rsp0_zero : rsp1_zero, {31'b0, ez});
        tick();
        chk({tag, "_rsp_done"},    (port == 0) ? rsp0_valid : rsp1_valid, 32'd0);
    endtask

    initial begin
        rst_n      = 1'b0;
        req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sel = OP_ADD;
        req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sel = OP_ADD;
        rsp0_ready = 1'b1; rsp1_ready = 1'b1;
        tick();
        tick();

        chk("rst_rsp0_valid", rsp0_valid, 32'd0);
        chk("rst_rsp1_valid", rsp1_valid, 32'd0);
        chk("rst_alu_a",      alu_a,      32'd0);
        chk("rst_alu_b",      alu_b,      32'd0);
        chk("rst_alu_sel",    alu_sel,    32'd2);
        chk("rst_rsp_result", rsp0_result, 32'd0);
        rst_n = 1'b1;
        tick();

        issue(0, 32'd5, 32'd3, OP_ADD);
        serve(0, 32'd8, 1'b0, "add");

        // Tie straight out of reset: port 0 wins first.
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        issue(0, 32'd7, 32'd7, OP_SUB);
        issue(1, 32'h0F, 32'hF0, OP_OR);
        serve(0, 32'd0, 1'b1, "tie_sub");
        issue(0, 32'hFF, 32'h0F, OP_AND);
`ifdef ALU_ARB_FIXED_PRIO_EN
        serve(0, 32'h0F, 1'b0, "tie2_and");
        serve(1, 32'hFF, 1'b0, "tie2_or");
`else
        serve(1, 32'hFF, 1'b0, "tie2_or");
        serve(0, 32'h0F, 1'b0, "tie2_and");
`endif

        // Backpressure on port 1 while port 0 waits.
        rsp1_ready = 1'b0;
        issue(1, 32'd1, 32'd4, OP_SLL);
        #1;
        chk("sll_ready", req1_ready, 32'd1);
        tick();
        req1_valid = 1'b0;
        tick();
        issue(0, 32'd6, 32'd7, OP_MUL);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_rsp1_valid", rsp1_valid,  32'd1);
            chk("bp_rsp1_res",   rsp1_result, 32'd16);
            chk("bp_rsp0_valid", rsp0_valid,  32'd0);
            chk("bp_req0_ready", req0_ready,  32'd0);
            chk("bp_alu_a",      alu_a,       32'd1);
            tick();
        end
        rsp1_ready = 1'b1;
        #1;
        chk("bp_release_valid", rsp1_valid,  32'd1);
        chk("bp_release_res",   rsp1_result, 32'd16);
        tick();
        chk("bp_done_valid", rsp1_valid, 32'd0);
        serve(0, 32'd42, 1'b0, "mul");

        // Reset during EXEC drops the operation.
        issue(0, 32'd9, 32'd9, OP_ADD);
        #1;
        chk("abort_ready", req0_ready, 32'd1);
        tick();
        req0_valid = 1'b0;
        chk("abort_alu_a", alu_a, 32'd9);
        rst_n = 1'b0;
        tick();
        chk("abort_rsp0_valid", rsp0_valid, 32'd0);
        chk("abort_alu_sel",    alu_sel,    32'd2);
        chk("abort_alu_a0",     alu_a,      32'd0);
        chk("abort_alu_b0",     alu_b,      32'd0);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_no_rsp0", rsp0_valid, 32'd0);
            chk("abort_no_rsp1", rsp1_valid, 32'd0);
        end

        issue(0, 32'hFFFF_FFFE, 32'd1, OP_SLT);
        serve(0, 32'd1, 1'b0, "slt");
        issue(1, 32'h80, 32'd3, OP_SRL);
        serve(1, 32'h10, 1'b0, "srl");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule : tb_alu_arbiter

`default_nettype wire
